tv80_bus_model: RTL
===================

Name: tv80_bus_model

Overview:
- Parametrised Z80 bus-side memory and I/O model for tv80s benches. Replaces the per-test ad-hoc memory/IO arrays.
- Adds programmable wait states, ROM write protection and a backdoor load/peek port.
- Adds write-trace outputs for checkers, INTA vector response, and a scheduled BUSRQ generator.
- Sits between the tv80s bus pins and the testbench tasks (SETMEM/ASSERTMEM route through the backdoor).

Parameters:
- ADDR_W, 16, memory address width; memory depth is 2**ADDR_W bytes.
- IO_W, 8, number of low address bits decoding I/O space; IO depth is 2**IO_W.
- MEM_WAIT, 0, wait cycles inserted per memory access (0..15).
- IO_WAIT, 1, extra wait cycles per I/O access (0..15).
- ROM_TOP, 0, addresses below ROM_TOP reject CPU writes; 0 disables protection.
- INTA_VEC, 8'hFF, byte driven on di during interrupt acknowledge (m1_n=0, iorq_n=0).
- BUSRQ_START, 0, cycles after reset release before busrq_n asserts; 0 disables the generator.
- BUSRQ_LEN, 100, number of busak_n-low cycles to hold the bus before releasing.

Ports:
- clk  in  1  bus clock, same clock as the cpu.
- reset  in  1  synchronous, active-high.
- a  in  ADDR_W  cpu address.
- cpu_do  in  8  cpu write data.
- di  out  8  cpu read data.
- m1_n, mreq_n, iorq_n, rd_n, wr_n  in  1 each  cpu strobes, active low.
- busak_n  in  1  bus acknowledge from cpu.
- wait_n  out  1  to cpu wait_n.
- busrq_n  out  1  to cpu busrq_n.
- bd_we  in  1  backdoor write strobe.
- bd_addr  in  ADDR_W  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  mem[bd_addr], combinational.
- wr_count  out  16  committed cpu memory writes, wraps at 16'hFFFF->0.
- last_wr_addr  out  ADDR_W  address of last committed memory write.
- last_wr_data  out  8  data of last committed memory write.
- rom_viol  out  1  one-cycle pulse when a protected write is rejected.
- bd_collide  out  1  one-cycle pulse when a backdoor write drops a cpu write.
- busrq_done  out  1  sticky; set when a BUSRQ episode completes.

Behaviour:
- Reset values: wait_n=1, busrq_n=1, wr_count=0, last_wr_addr=0, last_wr_data=0, rom_viol=0, bd_collide=0, busrq_done=0. The access FSM is IDLE and the cycle counter is 0. Memory and IO contents are not cleared.
- Read data:
  - mem_q <= mem[a] and io_q <= io[a[IO_W-1:0]] every posedge.
  - di = INTA_VEC when m1_n=0 and iorq_n=0; otherwise io_q when iorq_n=0; otherwise mem_q.
- Access detection:
  - req_mem = !mreq_n & (!rd_n | !wr_n).
  - req_io = !iorq_n & m1_n & (!rd_n | !wr_n).
  - INTA is never an I/O access: no IO write, no IO wait states.
- Access FSM states: IDLE, WAIT, ACTIVE, DONE.
  - IDLE -> WAIT on a req rising edge (req this cycle, not last cycle) when N>0. N = MEM_WAIT for memory, MEM_WAIT+IO_WAIT for I/O.
  - IDLE -> ACTIVE on the same edge when N=0.
  - WAIT drives wait_n=0 for exactly N cycles, then goes to ACTIVE with wait_n=1.
  - ACTIVE: if wr_n=0, commit the write once, then go to DONE. A read goes straight to DONE.
  - DONE -> IDLE when the req deasserts.
  - A req dropping in WAIT or ACTIVE returns the FSM to IDLE with wait_n=1 and no commit.
- Write commit (memory):
  - mem[a] <= cpu_do only if a >= ROM_TOP, or ROM_TOP=0.
  - On commit, wr_count increments and last_wr_addr/last_wr_data update.
  - A protected write leaves mem, wr_count and last_wr_* unchanged and pulses rom_viol.
- Write commit (I/O): io[a[IO_W-1:0]] <= cpu_do. I/O writes are not counted.
- Backdoor:
  - bd_we writes mem[bd_addr] <= bd_wdata regardless of ROM_TOP and regardless of FSM state.
  - If a cpu memory commit happens in the same cycle, only the backdoor write takes effect, even at a different address. The cpu write is dropped, bd_collide pulses, and wr_count does not increment.
- BUSRQ generator (BUSRQ_START>0):
  - A cycle counter runs from reset release.
  - busrq_n=0 at cycle BUSRQ_START.
  - While busrq_n=0, count cycles with busak_n=0.
  - When that count reaches BUSRQ_LEN, busrq_n=1 next cycle and busrq_done sets.
  - Runs once per reset; the counter saturates.
  - busak_n never asserting keeps busrq_n low indefinitely.
- Reset mid-access forces IDLE and wait_n=1 in the same cycle and discards the pending commit.

Test Plan:
- MEM_WAIT=0: backdoor-load 0000:B4 and DCA6:49; cpu A=F5, H=DC -> after 1 instruction A=FD, PC=0001, R=01; wr_count=0.
- MEM_WAIT=2: LD (8000h),A with A=5A -> wait_n low 2 cycles on every memory access; mem[8000]=5A; wr_count=1; last_wr_addr=8000; last_wr_data=5A.
- ROM_TOP=16'h4000: LD (1234h),A -> mem[1234] unchanged; rom_viol pulses once; wr_count=0.
- IO_WAIT=1, MEM_WAIT=0: OUT (7Fh),A with A=3C, then IN A,(7Fh) -> io[7F]=3C; A=3C; wait_n low exactly 1 cycle per I/O cycle.
- BUSRQ_START=300, BUSRQ_LEN=100, NOP loop: busrq_n falls at cycle 300; it rises 100 busak_n-low cycles later; busrq_done=1; PC resumes incrementing.
- Collision: force bd_we with bd_addr=9000, bd_wdata=11 on the cpu commit cycle of LD (8000h),A (A=22) -> mem[9000]=11; mem[8000] unchanged; bd_collide=1 for one cycle; wr_count unchanged.

Source files
------------

// File: rtl/tv80_bus_model.sv
// Bus-side memory/IO model for tv80s benches: wait-state insertion, ROM write
// protection, backdoor load/peek, write trace, INTA vector and a one-shot BUSRQ generator.
module tv80_bus_model #(
    parameter int          ADDR_W      = 16,
    parameter int          IO_W        = 8,
    parameter int          MEM_WAIT    = 0,
    parameter int          IO_WAIT     = 1,
    parameter int unsigned ROM_TOP     = 0,
    parameter logic [7:0]  INTA_VEC    = 8'hFF,
    parameter int unsigned BUSRQ_START = 0,
    parameter int unsigned BUSRQ_LEN   = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a,
    input  logic [7:0]        cpu_do,
    output logic [7:0]        di,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              busak_n,
    output logic              wait_n,
    output logic              busrq_n,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata,
    output logic [15:0]       wr_count,
    output logic [ADDR_W-1:0] last_wr_addr,
    output logic [7:0]        last_wr_data,
    output logic              rom_viol,
    output logic              bd_collide,
    output logic              busrq_done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DONE} state_t;

    localparam logic [4:0] N_MEM = 5'(MEM_WAIT);
    localparam logic [4:0] N_IO  = 5'(MEM_WAIT + IO_WAIT);

    logic [7:0]  mem [0:(2**ADDR_W)-1];
    logic [7:0]  io  [0:(2**IO_W)-1];
    logic [7:0]  mem_q;
    logic [7:0]  io_q;
    logic        req_mem, req_io, req, req_r;
    state_t      state, state_next;
    logic [4:0]  wcnt, wcnt_next, start_n;
    logic        is_io, is_io_next;
    logic        commit, mem_commit, io_commit, rom_ok, cpu_mem_wr;
    logic [31:0] cyc;
    logic [31:0] ak_cnt;

    assign req_mem    = !mreq_n & (!rd_n | !wr_n);
    assign req_io     = !iorq_n & m1_n & (!rd_n | !wr_n);
    assign req        = req_mem | req_io;
    assign start_n    = req_io ? N_IO : N_MEM;
    assign commit     = (state == S_ACTIVE) & req & !wr_n & !reset;
    assign mem_commit = commit & !is_io;
    assign io_commit  = commit & is_io;
    assign rom_ok     = (ROM_TOP == 32'd0) || (32'(a) >= ROM_TOP);
    // A backdoor write always wins the memory port, even at another address.
    assign cpu_mem_wr = mem_commit & rom_ok & !bd_we;

    assign wait_n   = !((state == S_WAIT) & req & !reset);
    assign di       = (!m1_n && !iorq_n) ? INTA_VEC : (!iorq_n ? io_q : mem_q);
    assign bd_rdata = mem[bd_addr];

    // Access FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            wcnt  <= 5'd0;
            is_io <= 1'b0;
            req_r <= 1'b0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            is_io <= is_io_next;
            req_r <= req;
        end
    end

    // Access FSM next-state logic
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        is_io_next = is_io;
        case (state)
            S_IDLE: begin
                if (req && !req_r) begin
                    is_io_next = req_io;
                    if (start_n != 5'd0) begin
                        state_next = S_WAIT;
                        wcnt_next  = start_n - 5'd1;
                    end else begin
                        state_next = S_ACTIVE;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_next = S_IDLE;
                end else if (wcnt == 5'd0) begin
                    state_next = S_ACTIVE;
                end else begin
                    wcnt_next = wcnt - 5'd1;
                end
            end
            S_ACTIVE: begin
                if (!req) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Memory array with registered read
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end else if (cpu_mem_wr) begin
            mem[a] <= cpu_do;
        end
        mem_q <= mem[a];
    end

    // I/O array with registered read
    always_ff @(posedge clk) begin
        if (io_commit) begin
            io[a[IO_W-1:0]] <= cpu_do;
        end
        io_q <= io[a[IO_W-1:0]];
    end

    // Write trace and event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count     <= 16'd0;
            last_wr_addr <= '0;
            last_wr_data <= 8'd0;
            rom_viol     <= 1'b0;
            bd_collide   <= 1'b0;
        end else begin
            rom_viol   <= mem_commit & !rom_ok;
            bd_collide <= mem_commit & rom_ok & bd_we;
            if (cpu_mem_wr) begin
                wr_count     <= wr_count + 16'd1;
                last_wr_addr <= a;
                last_wr_data <= cpu_do;
            end
        end
    end

    // One-shot BUSRQ generator
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc        <= 32'd0;
            ak_cnt     <= 32'd0;
            busrq_n    <= 1'b1;
            busrq_done <= 1'b0;
        end else begin
            if (cyc != BUSRQ_START) begin
                cyc <= cyc + 32'd1;
            end
            if (BUSRQ_START != 32'd0 && !busrq_done) begin
                if (busrq_n && cyc == BUSRQ_START - 32'd1) begin
                    busrq_n <= 1'b0;
                end else if (!busrq_n && !busak_n) begin
                    ak_cnt <= ak_cnt + 32'd1;
                    if (ak_cnt == BUSRQ_LEN - 32'd1) begin
                        busrq_n    <= 1'b1;
                        busrq_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
